// File: rtl/clkdiv_prog.sv
`default_nettype none
// ============================================================================
// Module   : clkdiv_prog
// Brief    : Runtime-programmable integer clock divider with ~50% duty clkout,
//            clock-enable strobe, glitch-free ratio change and calib phase slip.
// Revision : 1.0 - initial release
// ============================================================================
module clkdiv_prog #(
    parameter int WIDTH       = 8,
    parameter int RESET_RATIO = 5
) (
    input  logic             hclkin,
    input  logic             resetn,
    input  logic             calib,
    input  logic [WIDTH-1:0] div_ratio,
    input  logic             div_load,
    output logic             clkout,
    output logic             clk_en,
    output logic             div_ack,
    output logic             div_err,
    output logic [WIDTH-1:0] cur_ratio
);

    localparam logic [WIDTH-1:0] C_RST_RATIO = WIDTH'(RESET_RATIO);
    localparam logic [WIDTH-1:0] C_RST_CNT   = WIDTH'(RESET_RATIO - 1);

    generate
        if (RESET_RATIO < 2 || RESET_RATIO > (2 ** WIDTH) - 1) begin : g_bad_reset_ratio
            $error("clkdiv_prog: RESET_RATIO out of range 2..2^WIDTH-1");
        end
    endgenerate

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_ratio;
    logic [WIDTH-1:0] r_pend_ratio;
    logic             r_pend_valid;
    logic             r_calib_q;
    logic             r_clkout;
    logic             r_clk_en;
    logic             r_div_ack;
    logic             r_div_err;

    logic             w_slip;
    logic             w_wrap;
    logic             w_apply;
    logic             w_load_ok;
    logic             w_load_bad;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] w_ratio_nxt;
    logic [WIDTH:0]   w_hi_nxt;

    assign w_slip      = calib & ~r_calib_q;
    assign w_wrap      = (r_cnt == (r_ratio - WIDTH'(1)));
    assign w_apply     = ~w_slip & w_wrap & r_pend_valid;
    assign w_load_ok   = div_load & (div_ratio >= WIDTH'(2));
    assign w_load_bad  = div_load & (div_ratio <  WIDTH'(2));

    // A slip freezes cnt and ratio, so the registered outputs hold naturally.
    assign w_cnt_nxt   = w_slip ? r_cnt : (w_wrap ? '0 : r_cnt + WIDTH'(1));
    assign w_ratio_nxt = w_apply ? r_pend_ratio : r_ratio;
    assign w_hi_nxt    = ({1'b0, w_ratio_nxt} + (WIDTH+1)'(1)) >> 1;

    always_ff @(posedge hclkin or negedge resetn) begin
        if (!resetn) begin
            r_cnt        <= C_RST_CNT;
            r_ratio      <= C_RST_RATIO;
            r_pend_ratio <= C_RST_RATIO;
            r_pend_valid <= 1'b0;
            r_calib_q    <= 1'b1;
            r_clkout     <= 1'b0;
            r_clk_en     <= 1'b0;
            r_div_ack    <= 1'b0;
            r_div_err    <= 1'b0;
        end else begin
            r_calib_q <= calib;
            r_cnt     <= w_cnt_nxt;
            r_ratio   <= w_ratio_nxt;
            r_clkout  <= ({1'b0, w_cnt_nxt} < w_hi_nxt);
            r_clk_en  <= (w_cnt_nxt == '0);
            r_div_ack <= w_apply;
            r_div_err <= w_load_bad;
            // A load landing on an applying wrap becomes the next pending value.
            if (w_load_ok) begin
                r_pend_ratio <= div_ratio;
                r_pend_valid <= 1'b1;
            end else if (w_apply) begin
                r_pend_valid <= 1'b0;
            end
        end
    end

    assign clkout    = r_clkout;
    assign clk_en    = r_clk_en;
    assign div_ack   = r_div_ack;
    assign div_err   = r_div_err;
    assign cur_ratio = r_ratio;

endmodule
`default_nettype wire

// File: tb/tb_clkdiv_prog.sv
`default_nettype none
// ============================================================================
// Module   : tb_clkdiv_prog
// Brief    : Directed self-checking bench for clkdiv_prog (WIDTH=8, RESET_RATIO=5).
// Revision : 1.0 - initial release
// ============================================================================
module tb_clkdiv_prog;

    logic       hclkin;
    logic       resetn;
    logic       calib;
    logic [7:0] div_ratio;
    logic       div_load;
    logic       clkout;
    logic       clk_en;
    logic       div_ack;
    logic       div_err;
    logic [7:0] cur_ratio;

    int n_tot = 0;
    int n_bad = 0;

    // Expected-behaviour state: phase, active ratio, pending load, calib history.
    int   ph;
    int   r;
    int   pend_r;
    logic pend;
    logic cprev;
    int   since_en;
    int   last_per;

    clkdiv_prog #(.WIDTH(8), .RESET_RATIO(5)) u_dut (
        .hclkin    (hclkin),
        .resetn    (resetn),
        .calib     (calib),
        .div_ratio (div_ratio),
        .div_load  (div_load),
        .clkout    (clkout),
        .clk_en    (clk_en),
        .div_ack   (div_ack),
        .div_err   (div_err),
        .cur_ratio (cur_ratio)
    );

    initial hclkin = 1'b0;
    always #5 hclkin = ~hclkin;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        ph       = 4;
        r        = 5;
        pend     = 1'b0;
        pend_r   = 0;
        cprev    = 1'b1;
        since_en = 0;
        last_per = 0;
    endtask

    // One hclkin cycle: predict from current inputs, clock, then compare.
    task automatic cyc();
        logic slip;
        logic e_ack;
        logic e_err;
        slip  = calib && !cprev;
        e_ack = 1'b0;
        e_err = div_load && (div_ratio < 8'd2);
        if (!slip) begin
            if (ph == r - 1) begin
                ph = 0;
                if (pend) begin
                    r     = pend_r;
                    pend  = 1'b0;
                    e_ack = 1'b1;
                end
            end else begin
                ph = ph + 1;
            end
        end
        if (div_load && div_ratio >= 8'd2) begin
            pend   = 1'b1;
            pend_r = int'(div_ratio);
        end
        cprev = calib;
        @(posedge hclkin);
        @(negedge hclkin);
        chk("clkout",    32'(clkout),    32'(ph < (r + 1) / 2));
        chk("clk_en",    32'(clk_en),    32'(ph == 0));
        chk("div_ack",   32'(div_ack),   32'(e_ack));
        chk("div_err",   32'(div_err),   32'(e_err));
        chk("cur_ratio", 32'(cur_ratio), 32'(r));
        since_en++;
        if (clk_en) begin
            last_per = since_en;
            since_en = 0;
        end
    endtask

    task automatic run_to_ph(input int target);
        for (int k = 0; k < 300 && ph != target; k++) cyc();
    endtask

    initial begin
        resetn    = 1'b0;
        calib     = 1'b0;
        div_ratio = 8'd0;
        div_load  = 1'b0;
        model_reset();

        // Reset state
        repeat (3) @(negedge hclkin);
        chk("rst_clkout",    32'(clkout),    32'd0);
        chk("rst_clk_en",    32'(clk_en),    32'd0);
        chk("rst_div_ack",   32'(div_ack),   32'd0);
        chk("rst_div_err",   32'(div_err),   32'd0);
        chk("rst_cur_ratio", 32'(cur_ratio), 32'd5);

        // Free run at ratio 5: clk_en on cycles 1,6,11; clkout 1,1,1,0,0
        resetn = 1'b1;
        repeat (11) cyc();

        // Ratio change to 8 requested at cnt=2
        run_to_ph(2);
        div_ratio = 8'd8;
        div_load  = 1'b1;
        cyc();
        div_load  = 1'b0;
        cyc();
        cyc();
        chk("to8_ack_wrap", 32'(div_ack & clk_en), 32'd1);
        chk("to8_ratio",    32'(cur_ratio),        32'd8);
        repeat (16) cyc();

        // Overwriting load: 7 then 3 within one period, single ack
        run_to_ph(1);
        div_ratio = 8'd7;
        div_load  = 1'b1;
        cyc();
        div_load  = 1'b0;
        cyc();
        div_ratio = 8'd3;
        div_load  = 1'b1;
        cyc();
        div_load  = 1'b0;
        repeat (12) cyc();
        chk("to3_ratio", 32'(cur_ratio), 32'd3);

        // Rejected ratios 1 and 0
        div_ratio = 8'd1;
        div_load  = 1'b1;
        cyc();
        div_load  = 1'b0;
        repeat (4) cyc();
        div_ratio = 8'd0;
        div_load  = 1'b1;
        cyc();
        div_load  = 1'b0;
        repeat (6) cyc();
        chk("err_ratio_kept", 32'(cur_ratio), 32'd3);

        // Back to ratio 5, then calib rise at cnt=4 held for 10 cycles
        div_ratio = 8'd5;
        div_load  = 1'b1;
        cyc();
        div_load  = 1'b0;
        for (int k = 0; k < 10 && r != 5; k++) cyc();
        run_to_ph(4);
        calib = 1'b1;
        cyc();
        cyc();
        chk("slip_period", 32'(last_per), 32'd6);
        repeat (8) cyc();
        calib = 1'b0;
        repeat (7) cyc();
        chk("post_slip_period", 32'(last_per), 32'd5);

        // Reset mid-period with load of 9 pending
        run_to_ph(2);
        div_ratio = 8'd9;
        div_load  = 1'b1;
        cyc();
        div_load  = 1'b0;
        cyc();
        #2 resetn = 1'b0;
        #1;
        chk("mid_rst_clkout",  32'(clkout),    32'd0);
        chk("mid_rst_clk_en",  32'(clk_en),    32'd0);
        chk("mid_rst_div_ack", 32'(div_ack),   32'd0);
        chk("mid_rst_ratio",   32'(cur_ratio), 32'd5);
        @(negedge hclkin);
        resetn = 1'b1;
        model_reset();
        repeat (15) cyc();
        chk("post_rst_ratio", 32'(cur_ratio), 32'd5);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
